// File: rtl/load_store_unit_pkg.sv
// Shared RV32I load/store definitions: funct3 encodings, LSU FSM states,
// default memory timeout and the request legality rule.
package load_store_unit_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam int unsigned LSU_TIMEOUT_DEFAULT = 16;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_DONE   = 2'd2
  } lsu_state_e;

  // Illegal encodings are folded into the misalignment rule.
  function automatic logic req_ok(input logic is_load, input logic [2:0] f3,
                                  input logic [1:0] off);
    case (f3)
      F3_B:    req_ok = 1'b1;
      F3_H:    req_ok = ~off[0];
      F3_W:    req_ok = (off == 2'b00);
      F3_BU:   req_ok = is_load;
      F3_HU:   req_ok = is_load & ~off[0];
      default: req_ok = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_store_unit_load_extend.sv
// Load lane select and sign/zero extension of a memory read word.
module load_extend
  import load_store_unit_pkg::*;
(
  input  logic [2:0]  i_f3,
  input  logic [1:0]  i_off,
  input  logic [31:0] i_rdata,
  output logic [31:0] o_result
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  assign w_byte = i_rdata[{i_off, 3'b000} +: 8];
  assign w_half = i_rdata[{i_off[1], 4'b0000} +: 16];

  always_comb begin
    o_result = i_rdata;
    case (i_f3)
      F3_B:    o_result = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_result = {24'd0, w_byte};
      F3_H:    o_result = {{16{w_half[15]}}, w_half};
      F3_HU:   o_result = {16'd0, w_half};
      default: o_result = i_rdata;
    endcase
  end

endmodule

// File: rtl/load_store_unit.sv
// Load/store unit: stalls the datapath while one aligned memory access is
// in flight, formats store lanes, extends load data and flags errors/timeouts.
module load_store_unit
  import load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT = LSU_TIMEOUT_DEFAULT
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        memRead,
  input  logic        memWrite,
  input  logic [2:0]  f3,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] readData,
  output logic        stall,
  output logic        err,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_ack,
  input  logic [31:0] mem_rdata
);

  lsu_state_e  r_state, w_next;
  logic [7:0]  r_cnt;
  logic [2:0]  r_f3;
  logic [1:0]  r_off;
  logic        w_req, w_ok, w_start, w_bad, w_timeout;
  logic [3:0]  w_st_be;
  logic [31:0] w_st_data, w_ld_result;

  assign w_req     = memRead | memWrite;
  assign w_ok      = (memRead ^ memWrite) && req_ok(memRead, f3, addr[1:0]);
  assign w_timeout = (r_cnt == 8'(TIMEOUT - 1));

  always_comb begin
    w_st_be   = 4'b1111;
    w_st_data = wdata;
    case (f3)
      F3_B: begin
        w_st_be   = 4'b0001 << addr[1:0];
        w_st_data = {4{wdata[7:0]}};
      end
      F3_H: begin
        w_st_be   = addr[1] ? 4'b1100 : 4'b0011;
        w_st_data = {2{wdata[15:0]}};
      end
      default: ;
    endcase
  end

  load_extend u_load_extend (
    .i_f3     (r_f3),
    .i_off    (r_off),
    .i_rdata  (mem_rdata),
    .o_result (w_ld_result)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= ST_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next  = r_state;
    stall   = 1'b0;
    w_start = 1'b0;
    w_bad   = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (w_req) begin
          if (w_ok) begin
            w_start = 1'b1;
            stall   = 1'b1;
            w_next  = ST_ACCESS;
          end else begin
            w_bad = 1'b1;
          end
        end
      end
      ST_ACCESS: begin
        stall = 1'b1;
        if (mem_ack || w_timeout) w_next = ST_DONE;
      end
      ST_DONE: w_next = ST_IDLE;
      default: w_next = ST_IDLE;
    endcase
    if (rst) stall = 1'b0;
  end

  // Ack takes priority over timeout when both land in the same cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      readData  <= '0;
      err       <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      mem_be    <= '0;
      r_cnt     <= '0;
      r_f3      <= '0;
      r_off     <= '0;
    end else begin
      err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_start) begin
            mem_req   <= 1'b1;
            mem_we    <= memWrite;
            mem_be    <= memRead ? 4'b1111 : w_st_be;
            mem_addr  <= {addr[31:2], 2'b00};
            mem_wdata <= w_st_data;
            r_f3      <= f3;
            r_off     <= addr[1:0];
            r_cnt     <= '0;
          end else if (w_bad) begin
            err      <= 1'b1;
            readData <= '0;
          end
        end
        ST_ACCESS: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            if (!mem_we) readData <= w_ld_result;
          end else if (w_timeout) begin
            mem_req  <= 1'b0;
            err      <= 1'b1;
            readData <= '0;
          end else begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: ;
      endcase
    end
  end

endmodule
